// File: rtl/bit_pixel_pkg.sv
// Shared definitions for the bit-pixel writer and reader: FSM states,
// region tags and the RAM-geometry constant functions.
package bit_pixel_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_WRITING  = 2'd1,
    ST_COMMIT   = 2'd2
  } statetype;

  typedef enum logic [1:0] {
    RG_LEFT   = 2'd0,
    RG_CENTER = 2'd1,
    RG_RIGHT  = 2'd2
  } region_t;

  function automatic int unsigned row_width(input int unsigned tw, input int unsigned cw);
    return 2 * tw + cw;
  endfunction

  function automatic int unsigned third_reads(input int unsigned tw, input int unsigned th);
    return tw * th / 8;
  endfunction

  function automatic int unsigned center_reads(input int unsigned cw, input int unsigned th);
    return cw * th / 8;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs a serial 1-bit pixel stream into bytes, first pixel in bit 0.
module bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_valid,
  input  logic       i_bit,
  output logic [7:0] o_byte,
  output logic       o_byte_done
);

  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic [7:0] w_base;
  logic [2:0] w_cnt;

  // A clear qualified with a valid bit makes that bit the first of a fresh byte.
  always_comb begin
    w_base      = i_clear ? '0 : r_shift;
    w_cnt       = i_clear ? '0 : r_cnt;
    o_byte      = {i_bit, w_base[7:1]};
    o_byte_done = i_valid && (w_cnt == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= o_byte;
      r_cnt   <= w_cnt + 3'd1;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end
  end

endmodule

// File: rtl/bit_pixel_writer.sv
// Packs a binarized raster stream into the double-buffered left, center and
// right bit-pixel RAMs and publishes a completed-frame counter.
module bit_pixel_writer
  import bit_pixel_pkg::*;
#(
  parameter int unsigned third_width  = 240,
  parameter int unsigned third_height = 480,
  parameter int unsigned center_width = 304
) (
  input  logic        pclk,
  input  logic        pclk_reset,
  input  logic        pixel_in,
  input  logic        pixel_valid,
  input  logic        pixel_sof,
  output logic        pixel_ready,
  output logic [3:0]  image_number,
  output logic [15:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        wr_en_left,
  output logic        wr_en_centerleft,
  output logic        wr_en_centerright,
  output logic        wr_en_right,
  output logic        sof_error
);

  localparam int unsigned ROW_W    = row_width(third_width, center_width);
  localparam int unsigned COL_W    = $clog2(ROW_W);
  localparam int unsigned ROW_BITS = (third_height > 1) ? $clog2(third_height) : 1;

  localparam logic [15:0] TR = 16'(third_reads(third_width, third_height));
  localparam logic [15:0] CR = 16'(center_reads(center_width, third_height));
  localparam logic [15:0] TB = 16'(third_width / 8);
  localparam logic [15:0] CB = 16'(center_width / 8);

  localparam logic [COL_W-1:0]    LAST_COL = COL_W'(ROW_W - 1);
  localparam logic [COL_W-1:0]    C_START  = COL_W'(third_width);
  localparam logic [COL_W-1:0]    R_START  = COL_W'(third_width + center_width);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(third_height - 1);

  statetype            r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_BITS-1:0] r_row;
  logic [15:0]         r_lbase;
  logic [15:0]         r_cbase;
  logic                r_wr_buf;
  logic [3:0]          r_image_number;
  logic                r_ready;
  logic [15:0]         r_addr;
  logic [7:0]          r_data;
  logic                r_en_l;
  logic                r_en_c;
  logic                r_en_r;
  logic                r_sof_error;

  logic        w_accept;
  logic        w_sof;
  logic        w_pk_valid;
  logic        w_byte_done;
  logic [7:0]  w_byte;
  region_t     w_region;
  logic [15:0] w_col_off;
  logic [15:0] w_addr;

  assign w_accept   = pixel_valid && r_ready;
  assign w_sof      = w_accept && pixel_sof;
  // Pixels seen while waiting for a frame start only reach the packer if they carry sof.
  assign w_pk_valid = w_accept && ((r_state == ST_WRITING) || pixel_sof);

  bit_packer u_packer (
    .clk         (pclk),
    .rst         (pclk_reset),
    .i_clear     (w_sof),
    .i_valid     (w_pk_valid),
    .i_bit       (pixel_in),
    .o_byte      (w_byte),
    .o_byte_done (w_byte_done)
  );

  always_comb begin
    w_region  = RG_RIGHT;
    w_col_off = 16'(r_col - R_START);
    if (r_col < C_START) begin
      w_region  = RG_LEFT;
      w_col_off = 16'(r_col);
    end else if (r_col < R_START) begin
      w_region  = RG_CENTER;
      w_col_off = 16'(r_col - C_START);
    end
    // Row bases are kept as running sums so no row multiply is needed.
    if (w_region == RG_CENTER) begin
      w_addr = (r_wr_buf ? CR : '0) + r_cbase + (w_col_off >> 3);
    end else begin
      w_addr = (r_wr_buf ? TR : '0) + r_lbase + (w_col_off >> 3);
    end
  end

  always_ff @(posedge pclk) begin
    if (pclk_reset) begin
      r_state        <= ST_WAIT_SOF;
      r_col          <= '0;
      r_row          <= '0;
      r_lbase        <= '0;
      r_cbase        <= '0;
      r_wr_buf       <= 1'b0;
      r_image_number <= '0;
      r_ready        <= 1'b0;
      r_addr         <= '0;
      r_data         <= '0;
      r_en_l         <= 1'b0;
      r_en_c         <= 1'b0;
      r_en_r         <= 1'b0;
      r_sof_error    <= 1'b0;
    end else begin
      r_en_l      <= 1'b0;
      r_en_c      <= 1'b0;
      r_en_r      <= 1'b0;
      r_sof_error <= 1'b0;

      if (w_byte_done) begin
        r_data <= w_byte;
        r_addr <= w_addr;
        r_en_l <= (w_region == RG_LEFT);
        r_en_c <= (w_region == RG_CENTER);
        r_en_r <= (w_region == RG_RIGHT);
      end

      unique case (r_state)
        ST_WAIT_SOF: begin
          r_ready <= 1'b1;
          if (w_sof) begin
            r_col   <= COL_W'(1);
            r_row   <= '0;
            r_lbase <= '0;
            r_cbase <= '0;
            r_state <= ST_WRITING;
          end
        end
        ST_WRITING: begin
          r_ready <= 1'b1;
          if (w_sof) begin
            r_sof_error <= 1'b1;
            r_col       <= COL_W'(1);
            r_row       <= '0;
            r_lbase     <= '0;
            r_cbase     <= '0;
          end else if (w_accept) begin
            if (r_col == LAST_COL) begin
              r_col <= '0;
              if (r_row == LAST_ROW) begin
                r_ready <= 1'b0;
                r_state <= ST_COMMIT;
              end else begin
                r_row   <= r_row + ROW_BITS'(1);
                r_lbase <= r_lbase + TB;
                r_cbase <= r_cbase + CB;
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          r_wr_buf       <= ~r_wr_buf;
          r_image_number <= r_image_number + 4'd1;
          r_row          <= '0;
          r_lbase        <= '0;
          r_cbase        <= '0;
          r_ready        <= 1'b1;
          r_state        <= ST_WAIT_SOF;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_WAIT_SOF;
        end
      endcase
    end
  end

  assign pixel_ready       = r_ready;
  assign image_number      = r_image_number;
  assign wr_address        = r_addr;
  assign wr_data           = r_data;
  assign wr_en_left        = r_en_l;
  assign wr_en_centerleft  = r_en_c;
  assign wr_en_centerright = r_en_c;
  assign wr_en_right       = r_en_r;
  assign sof_error         = r_sof_error;

endmodule

// File: doc/bit_pixel_writer.md
Name: bit_pixel_writer

Overview:
- Accepts a raster stream of binarized (1-bit) pixels and packs them 8 per byte.
- Writes the bytes into the left, center and right bit-pixel RAMs. The center byte is written to both the centerleft and centerright RAMs.
- The RAMs are double-buffered. After each complete frame the block toggles its write buffer and increments image_number, which the downstream bit-pixel reader polls.

Parameters:
- third_width, 240, pixel width of the left and right regions (multiple of 8)
- third_height, 480, rows per frame
- center_width, 304, pixel width of the center region (multiple of 8)

Ports:
- pclk  input  1  clock
- pclk_reset  input  1  synchronous active-high reset
- pixel_in  input  1  binarized pixel
- pixel_valid  input  1  pixel_in valid
- pixel_sof  input  1  qualifies the first pixel of a frame (sampled with pixel_valid)
- pixel_ready  output  1  block accepts a pixel this cycle
- image_number  output  4  completed-frame counter
- wr_address  output  16  shared RAM write address
- wr_data  output  8  packed byte; bit i = pixel at column offset i (bit 0 leftmost)
- wr_en_left  output  1  write strobe, left RAM
- wr_en_centerleft  output  1  write strobe, centerleft RAM
- wr_en_centerright  output  1  write strobe, centerright RAM (always equal to wr_en_centerleft)
- wr_en_right  output  1  write strobe, right RAM
- sof_error  output  1  one-cycle pulse when a frame is aborted by an early pixel_sof

Behaviour:
- Constants: row_width = 2*third_width + center_width. third_bytes = third_width/8. center_bytes = center_width/8. third_reads = third_width*third_height/8. center_reads = center_width*third_height/8.
- Accept rule: a pixel is accepted when pixel_valid && pixel_ready.
- Column regions:
  - columns [0, third_width) map to left;
  - [third_width, third_width+center_width) map to center;
  - the remaining columns map to right.
- Counters: col (0..row_width-1), row (0..third_height-1), bit index 0..7, and wr_buf (0/1).
- Address = base + row*region_bytes + (col_in_region/8).
  - Left/right base = wr_buf ? third_reads : 0.
  - Center base = wr_buf ? center_reads : 0.
  - Row multiply is replaced by per-region running row-base registers.
- Write timing: on acceptance of the 8th pixel of a byte, wr_data, wr_address and exactly one region strobe (center: both center strobes) are registered. They are valid for exactly one cycle, the cycle after acceptance. Write latency is 1 cycle. No other cycle asserts any strobe.
- States:
  - ST_WAIT_SOF: pixel_ready=1. Accepted pixels without pixel_sof are discarded. An accepted pixel with pixel_sof is stored as col 0/row 0 -> ST_WRITING.
  - ST_WRITING: pixel_ready=1.
    - Col wraps at row_width-1 and row increments.
    - Acceptance of pixel (row_width-1, third_height-1) -> ST_COMMIT.
    - An accepted pixel_sof in this state (other than at col 0/row 0 by construction): pulse sof_error, restart the frame at col 0/row 0 in the same wr_buf with this pixel as the first pixel. Partial bytes are dropped and image_number is unchanged.
  - ST_COMMIT (1 cycle): pixel_ready=0. The final byte write is on the strobes this cycle. wr_buf toggles, image_number increments (wraps 15->0) -> ST_WAIT_SOF. image_number changes one cycle after the last write strobe, so all data is in RAM before the reader sees the new number.
- Reset values: pixel_ready=0 during reset, then 1. image_number=0, wr_buf=0, all strobes 0, wr_data=0, wr_address=0, sof_error=0, state=ST_WAIT_SOF.
- Reset mid-frame: partial frame abandoned, no strobe on the cycle after reset, buffer back to 0.
- Address range: max address 2*center_reads-1 = 36479, which fits 16 bits.

Decomposition:
- Shared package bit_pixel_pkg holds:
  - statetype enums;
  - the third_reads/center_reads/row_width constant functions, also adopted by the reader.
- Sub-module bit_packer: 8-bit shift register with bit counter, flush/clear input and byte_done output.
- Region/address logic stays in the top.

Test Plan:
- Frame 0, row 0: cols 0..7 = 1,0,0,0,0,0,0,1 with sof on col 0 -> wr_en_left pulse, wr_address=0, wr_data=0x81. Cols 240..247 all 1 -> center strobes, addr 0, data 0xFF. Col 544..551 -> wr_en_right, addr 0.
- Row 1 col 0..7 -> left addr 30. Row 479 last right byte -> addr 14399. Then ST_COMMIT: pixel_ready low 1 cycle, image_number 0->1.
- Second frame -> left row 0 addr 14400, center addr 18240, last center addr 36479. image_number 1->2. Third frame -> addresses back to 0.
- pixel_sof asserted at row 10 col 100 -> sof_error pulse, next left write at addr 0, image_number unchanged. Pixels before the first-ever sof -> no strobes.
- Random pixel_valid gaps (50% duty) over one full frame -> RAM model matches the golden packed image, exactly 98*480 = 47040 strobe cycles (center counted once).
- pclk_reset asserted mid-row 200 -> all strobes 0, image_number=0. A subsequent full frame writes buffer 0 from addr 0.
